jtag_axi_txn_engine: RTL and testbench
======================================

Name: jtag_axi_txn_engine

Overview:
- AXI-side executor for JTAG-originated requests.
- Pops one command from a first-word-fall-through command FIFO and issues a single-beat AXI4 read or write on the master interface.
- Converts the B/R response into a JTAG status word, or produces a TIMEOUT status, and pushes it into the response FIFO headed back to the TCK domain.
- Sits between the two async FIFOs of the JTAG dispatch path, entirely in the AXI clock domain.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; legal values 32 or 64.
- ID_WIDTH, 8, AXI ID width.
- TXN_ID, 0, constant AWID/ARID value.
- TIMEOUT_CYCLES, 4096, clk cycles allowed from AXI issue to response; minimum 2.

Ports:
- clk  in  1  AXI clock.
- ares  in  1  asynchronous active-high reset.
- cmd_empty_i  in  1  command FIFO empty.
- cmd_rd_o  out  1  command FIFO pop.
- cmd_write_i  in  1  command type: 1 = write, 0 = read.
- cmd_size_i  in  3  AXI size encoding (bytes = 2^size).
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- cmd_wstrb_i  in  DATA_WIDTH/8  write strobes.
- rsp_full_i  in  1  response FIFO full.
- rsp_wr_o  out  1  response FIFO push.
- rsp_status_o  out  3  status code.
- rsp_rdata_o  out  DATA_WIDTH  read data.
- busy_o  out  1  a command is in flight (any state other than IDLE).
- timeout_o  out  1  sticky timeout flag.
- clr_timeout_i  in  1  clears timeout_o.
- AXI master channels:
  - aw: awvalid_o, awready_i, awaddr_o, awsize_o, awid_o, awlen_o, awburst_o
  - w: wvalid_o, wready_i, wdata_o, wstrb_o, wlast_o
  - b: bvalid_i, bready_o, bresp_i
  - ar: arvalid_o, arready_i, araddr_o, arsize_o, arid_o, arlen_o, arburst_o
  - r: rvalid_i, rready_o, rdata_i, rresp_i, rlast_i
  - Widths: addr/data/ID per parameters; size 3, len 8, burst 2, resp 2.

Behaviour:
- Reset: ares asserted -> all outputs 0, state IDLE, timeout_o 0. Applies asynchronously, including mid-transaction, with no drain.
- Status codes: 0 IDLE, 1 RUNNING, 2 OKAY, 3 EXOKAY, 4 SLVERR, 5 DECERR, 6 TIMEOUT.
- Response mapping: resp 00/01/10/11 -> 2/3/4/5. Write responses carry rsp_rdata_o = 0.
- Constant AXI fields: awlen/arlen = 0, burst = INCR (01), wlast = 1, IDs = TXN_ID.
- IDLE: when !cmd_empty_i, pulse cmd_rd_o for one cycle and register every cmd_* field that same cycle.
  - If 2^cmd_size_i > DATA_WIDTH/8 -> go to RSP with SLVERR; no AXI activity.
  - Else write -> WADDR; read -> RADDR.
- WADDR: awvalid_o and wvalid_o both rise the cycle after the pop.
  - Each drops independently on its own handshake. Either order or simultaneous handshakes are legal.
  - When both handshakes are complete -> WRESP.
- WRESP: bready_o = 1. On bvalid_i -> RSP with the mapped bresp_i.
- RADDR: arvalid_o = 1. On arready_i -> RDATA.
- RDATA: rready_o = 1. On rvalid_i -> capture rdata_i/rresp_i -> RSP.
- Valid stability: valids, once asserted, hold with stable payload until their handshake (AXI rule), even after a timeout.
- Timeout counter:
  - Cleared on entry to WADDR/RADDR; increments in WADDR, WRESP, RADDR, RDATA.
  - When count reaches TIMEOUT_CYCLES-1 with no completing handshake that cycle -> RSP with TIMEOUT, set timeout_o, mark pending-drain.
  - A response arriving in the same cycle as expiry wins; no timeout is reported.
- RSP: present status/data; assert rsp_wr_o for one cycle when !rsp_full_i.
  - While full, hold with no timeout counting.
  - After the push -> DRAIN if pending-drain is marked, else IDLE.
- DRAIN: complete any outstanding AW/W/AR handshakes, hold bready_o/rready_o = 1, discard the late response, then -> IDLE.
  - No timeout in DRAIN.
  - No new command is popped until DRAIN exits.
- timeout_o: stays 1 until clr_timeout_i. Clear and set in the same cycle -> set wins.
- Latency: pop to valid = 1 cycle. Response handshake to rsp_wr_o = 1 cycle when the response FIFO is not full.
- Throughput: at most one command in flight.

Test Plan:
- Write: addr 0x1000, wdata 0xDEADBEEF, size 2, wstrb 0xF; awready delayed 3 cycles, wready immediate, bresp 00 -> one rsp_wr_o with status 2, rdata 0; awvalid_o is held through the stall.
- Read: addr 0x2000, size 2; rdata 0xCAFEF00D, rresp 10 -> status 4, rdata 0xCAFEF00D; arlen 0, arid TXN_ID.
- Timeout: TIMEOUT_CYCLES = 16, arready never asserted -> status 6 pushed 16 cycles after arvalid rise, timeout_o = 1, arvalid_o stays high. A later arready plus rvalid is consumed with no second push, then the next command is popped. clr_timeout_i -> timeout_o 0.
- Illegal size: DATA_WIDTH = 32, size 3 -> status 4, no awvalid/arvalid ever asserted.
- Backpressure: rsp_full_i held 5 cycles at RSP -> rsp_wr_o waits, exactly one push, no timeout; a second queued command is not popped until after that push.
- Reset: ares pulsed during WRESP -> all outputs 0 immediately. A fresh read after reset completes with status 2.

Source files
------------

// File: rtl/jtag_axi_txn_engine.sv
// AXI-side executor for JTAG-originated requests: pops one command, runs a single-beat
// AXI4 read or write, and pushes a status/data word (or TIMEOUT) into the response FIFO.
module jtag_axi_txn_engine #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 8,
    parameter int TXN_ID         = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    ares,
    input  logic                    cmd_empty_i,
    output logic                    cmd_rd_o,
    input  logic                    cmd_write_i,
    input  logic [2:0]              cmd_size_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    input  logic                    rsp_full_i,
    output logic                    rsp_wr_o,
    output logic [2:0]              rsp_status_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    input  logic                    clr_timeout_i,
    output logic [2:0]              dbg_state_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [2:0]              awsize_o,
    output logic [ID_WIDTH-1:0]     awid_o,
    output logic [7:0]              awlen_o,
    output logic [1:0]              awburst_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    input  logic [1:0]              bresp_i,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    output logic [2:0]              arsize_o,
    output logic [ID_WIDTH-1:0]     arid_o,
    output logic [7:0]              arlen_o,
    output logic [1:0]              arburst_o,
    input  logic                    rvalid_i,
    output logic                    rready_o,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic [1:0]              rresp_i,
    input  logic                    rlast_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUNNING = 3'd1;
    localparam logic [2:0] ST_SLVERR  = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd6;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [2:0]            status_q, status_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  drain_q, drain_d;
    logic                  timeout_q, timeout_d;
    logic                  timeout_set;
    logic                  expired;
    logic                  b_hs, r_hs;
    logic                  unused_rlast;

    assign unused_rlast = rlast_i;

    // AXI resp 00/01/10/11 maps onto OKAY/EXOKAY/SLVERR/DECERR status codes 2..5.
    function automatic logic [2:0] map_resp(input logic [1:0] resp);
        return 3'd2 + {1'b0, resp};
    endfunction

    assign b_hs    = bvalid_i & bready_o;
    assign r_hs    = rvalid_i & rready_o;
    assign expired = (cnt_q >= CNT_LAST);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        // Valids drop only on their own handshake, in every state, so a timed-out
        // request still completes its address/data phase legally.
        awvalid_d   = awvalid_q & ~awready_i;
        wvalid_d    = wvalid_q & ~wready_i;
        arvalid_d   = arvalid_q & ~arready_i;
        status_d    = status_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        timeout_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!cmd_empty_i) begin
                    write_d = cmd_write_i;
                    size_d  = cmd_size_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    wstrb_d = cmd_wstrb_i;
                    rdata_d = '0;
                    drain_d = 1'b0;
                    cnt_d   = '0;
                    if (cmd_size_i > MAX_SIZE) begin
                        status_d = ST_SLVERR;
                        state_d  = S_RSP;
                    end else if (cmd_write_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WADDR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_WRESP;
                end else if (expired) begin
                    timeout_set = 1'b1;
                end
            end
            S_WRESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (b_hs) begin
                    status_d = map_resp(bresp_i);
                    state_d  = S_RSP;
                end else if (expired) begin
                    timeout_set = 1'b1;
                end
            end
            S_RADDR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (arvalid_q && arready_i) begin
                    state_d = S_RDATA;
                end else if (expired) begin
                    timeout_set = 1'b1;
                end
            end
            S_RDATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (r_hs) begin
                    rdata_d  = rdata_i;
                    status_d = map_resp(rresp_i);
                    state_d  = S_RSP;
                end else if (expired) begin
                    timeout_set = 1'b1;
                end
            end
            S_RSP: begin
                if (!rsp_full_i) begin
                    state_d = drain_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                // The late response is swallowed only once every request phase is done.
                if (!awvalid_q && !wvalid_q && !arvalid_q && (write_q ? b_hs : r_hs)) begin
                    drain_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_set) begin
            status_d = ST_TIMEOUT;
            rdata_d  = '0;
            drain_d  = 1'b1;
            state_d  = S_RSP;
        end
    end

    assign timeout_d = timeout_set ? 1'b1 : (clr_timeout_i ? 1'b0 : timeout_q);

    always_ff @(posedge clk or posedge ares) begin
        if (ares) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            status_q  <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_rd_o     = (state_q == S_IDLE) & ~cmd_empty_i;
    assign rsp_wr_o     = (state_q == S_RSP) & ~rsp_full_i;
    assign rsp_status_o = (state_q == S_RSP)  ? status_q :
                          (state_q == S_IDLE) ? ST_IDLE  : ST_RUNNING;
    assign rsp_rdata_o  = rdata_q;
    assign busy_o       = (state_q != S_IDLE);
    assign timeout_o    = timeout_q;
    assign dbg_state_o  = state_q;

    // Constant ID/burst fields are gated by their valid so every output reads 0 in reset.
    assign awvalid_o = awvalid_q;
    assign awaddr_o  = addr_q;
    assign awsize_o  = size_q;
    assign awid_o    = awvalid_q ? ID_WIDTH'(TXN_ID) : '0;
    assign awlen_o   = 8'd0;
    assign awburst_o = awvalid_q ? 2'b01 : 2'b00;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = wvalid_q;
    assign bready_o  = (state_q == S_WRESP) | (state_q == S_DRAIN);
    assign arvalid_o = arvalid_q;
    assign araddr_o  = addr_q;
    assign arsize_o  = size_q;
    assign arid_o    = arvalid_q ? ID_WIDTH'(TXN_ID) : '0;
    assign arlen_o   = 8'd0;
    assign arburst_o = arvalid_q ? 2'b01 : 2'b00;
    assign rready_o  = (state_q == S_RDATA) | (state_q == S_DRAIN);

endmodule

// File: tb/tb_jtag_axi_txn_engine.sv
// Table-driven bench for jtag_axi_txn_engine with hand sequences for timeout/drain,
// response backpressure and mid-transaction reset.
module tb_jtag_axi_txn_engine;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 8;
    localparam int TXN = 8'h3C;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          ares;
    logic          cmd_empty_i, cmd_rd_o, cmd_write_i;
    logic [2:0]    cmd_size_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic [3:0]    cmd_wstrb_i;
    logic          rsp_full_i, rsp_wr_o;
    logic [2:0]    rsp_status_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          busy_o, timeout_o, clr_timeout_i;
    logic [2:0]    dbg_state_o;
    logic          awvalid_o, awready_i;
    logic [AW-1:0] awaddr_o;
    logic [2:0]    awsize_o;
    logic [IW-1:0] awid_o;
    logic [7:0]    awlen_o;
    logic [1:0]    awburst_o;
    logic          wvalid_o, wready_i, wlast_o;
    logic [DW-1:0] wdata_o;
    logic [3:0]    wstrb_o;
    logic          bvalid_i, bready_o;
    logic [1:0]    bresp_i;
    logic          arvalid_o, arready_i;
    logic [AW-1:0] araddr_o;
    logic [2:0]    arsize_o;
    logic [IW-1:0] arid_o;
    logic [7:0]    arlen_o;
    logic [1:0]    arburst_o;
    logic          rvalid_i, rready_o, rlast_i;
    logic [DW-1:0] rdata_i;
    logic [1:0]    rresp_i;

    jtag_axi_txn_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TXN_ID(TXN), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .ares(ares),
        .cmd_empty_i(cmd_empty_i), .cmd_rd_o(cmd_rd_o), .cmd_write_i(cmd_write_i),
        .cmd_size_i(cmd_size_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .cmd_wstrb_i(cmd_wstrb_i), .rsp_full_i(rsp_full_i), .rsp_wr_o(rsp_wr_o),
        .rsp_status_o(rsp_status_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
        .timeout_o(timeout_o), .clr_timeout_i(clr_timeout_i), .dbg_state_o(dbg_state_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awsize_o(awsize_o),
        .awid_o(awid_o), .awlen_o(awlen_o), .awburst_o(awburst_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .wlast_o(wlast_o), .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arsize_o(arsize_o),
        .arid_o(arid_o), .arlen_o(arlen_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          write;
        logic [2:0]    size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        int            d_a;
        int            d_w;
        int            d_resp;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
        logic [2:0]    exp_status;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t        vecs[11];
    vec_t        hv;
    int          n_checks = 0;
    int          n_errors = 0;
    string       cur = "init";
    logic [34:0] exp_q[$];
    logic [34:0] exp_e;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h, expected %h", cur, name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response push must match the head of the expected queue.
    always @(negedge clk) begin
        if (!ares && rsp_wr_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s/rsp_unexpected: got status %0d rdata %h, expected no push",
                         cur, rsp_status_o, rsp_rdata_o);
            end else begin
                exp_e = exp_q.pop_front();
                if ({rsp_status_o, rsp_rdata_o} !== exp_e) begin
                    n_errors++;
                    $display("FAIL %s/rsp_push: got status %0d rdata %h, expected status %0d rdata %h",
                             cur, rsp_status_o, rsp_rdata_o, exp_e[34:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic set_cmd(input vec_t v);
        cmd_write_i = v.write;
        cmd_size_i  = v.size;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        cmd_wstrb_i = v.wstrb;
        cmd_empty_i = 1'b0;
    endtask

    task automatic push_cmd(input vec_t v);
        logic got;
        got = 1'b0;
        set_cmd(v);
        for (int k = 0; k < 50; k++) begin
            #1;
            if (cmd_rd_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("cmd_pop", 64'(got), 64'(1));
        tick();
        cmd_empty_i = 1'b1;
    endtask

    task automatic write_slave(input vec_t v);
        logic aw_done, w_done;
        int   cyc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        check("aw_payload", {awaddr_o, 5'd0, awsize_o, awlen_o, 6'd0, awburst_o, awid_o},
              {v.addr, 5'd0, v.size, 8'd0, 6'd0, 2'b01, 8'(TXN)});
        check("w_payload", {27'd0, wlast_o, wstrb_o, wdata_o}, {27'd0, 1'b1, v.wstrb, v.wdata});
        while (!(aw_done && w_done) && cyc < 100) begin
            check("awvalid_hold", 64'(awvalid_o), 64'(!aw_done));
            check("wvalid_hold", 64'(wvalid_o), 64'(!w_done));
            awready_i = !aw_done && (cyc >= v.d_a);
            wready_i  = !w_done && (cyc >= v.d_w);
            tick();
            if (awready_i) aw_done = 1'b1;
            if (wready_i) w_done = 1'b1;
            awready_i = 1'b0;
            wready_i  = 1'b0;
            cyc++;
        end
        check("aw_w_done", {awvalid_o, wvalid_o, bready_o}, {1'b0, 1'b0, 1'b1});
        repeat (v.d_resp) begin
            check("bready_wait", 64'(bready_o), 64'(1));
            tick();
        end
        bvalid_i = 1'b1;
        bresp_i  = v.resp;
        tick();
        bvalid_i = 1'b0;
        check("rsp_latency", 64'(rsp_wr_o), 64'(1));
        tick();
        check("back_idle", 64'(busy_o), 64'(0));
    endtask

    task automatic read_slave(input vec_t v);
        logic done;
        int   cyc;
        done = 1'b0;
        cyc  = 0;
        check("ar_payload", {araddr_o, 5'd0, arsize_o, arlen_o, 6'd0, arburst_o, arid_o},
              {v.addr, 5'd0, v.size, 8'd0, 6'd0, 2'b01, 8'(TXN)});
        check("no_aw_on_read", {awvalid_o, wvalid_o}, 64'(0));
        while (!done && cyc < 100) begin
            check("arvalid_hold", 64'(arvalid_o), 64'(1));
            arready_i = (cyc >= v.d_a);
            tick();
            if (arready_i) done = 1'b1;
            arready_i = 1'b0;
            cyc++;
        end
        check("ar_done", {arvalid_o, rready_o}, {1'b0, 1'b1});
        repeat (v.d_resp) begin
            check("rready_wait", 64'(rready_o), 64'(1));
            tick();
        end
        rvalid_i = 1'b1;
        rresp_i  = v.resp;
        rdata_i  = v.rdata;
        tick();
        rvalid_i = 1'b0;
        rdata_i  = '0;
        check("rsp_latency", 64'(rsp_wr_o), 64'(1));
        tick();
        check("back_idle", 64'(busy_o), 64'(0));
    endtask

    task automatic run_vec(input vec_t v);
        exp_q.push_back({v.exp_status, v.exp_rdata});
        push_cmd(v);
        if (v.size > 3'd2) begin
            check("illegal_no_axi", {awvalid_o, wvalid_o, arvalid_o}, 64'(0));
            check("illegal_rsp", 64'(rsp_wr_o), 64'(1));
            tick();
            check("illegal_idle", {busy_o, awvalid_o, arvalid_o}, 64'(0));
        end else if (v.write) begin
            write_slave(v);
        end else begin
            read_slave(v);
        end
        check("no_timeout", 64'(timeout_o), 64'(0));
    endtask

    function automatic logic any_output();
        return |{cmd_rd_o, rsp_wr_o, rsp_status_o, rsp_rdata_o, busy_o, timeout_o, dbg_state_o,
                 awvalid_o, awaddr_o, awsize_o, awid_o, awlen_o, awburst_o,
                 wvalid_o, wdata_o, wstrb_o, wlast_o, bready_o,
                 arvalid_o, araddr_o, arsize_o, arid_o, arlen_o, arburst_o, rready_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr    sz    addr          wdata         strb  da dw dr resp   rdata         st    exp_rdata
        vecs[0]  = '{1'b1, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 2'b00, 32'h0,        3'd2, 32'h0};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_2000, 32'h0,         4'h0, 0, 0, 0, 2'b10, 32'hCAFE_F00D, 3'd4, 32'hCAFE_F00D};
        vecs[2]  = '{1'b1, 3'd1, 32'h0000_3004, 32'h1234_0000, 4'hC, 0, 2, 1, 2'b01, 32'h0,        3'd3, 32'h0};
        vecs[3]  = '{1'b1, 3'd0, 32'h0000_4001, 32'h0000_AB00, 4'h2, 1, 1, 2, 2'b11, 32'h0,        3'd5, 32'h0};
        vecs[4]  = '{1'b1, 3'd2, 32'h0000_4100, 32'h5555_AAAA, 4'hF, 2, 4, 0, 2'b10, 32'h0,        3'd4, 32'h0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_5000, 32'h0,         4'h0, 2, 0, 3, 2'b01, 32'h0BAD_F00D, 3'd3, 32'h0BAD_F00D};
        vecs[6]  = '{1'b0, 3'd0, 32'h0000_5003, 32'h0,         4'h0, 1, 0, 0, 2'b11, 32'hA500_0000, 3'd5, 32'hA500_0000};
        vecs[7]  = '{1'b0, 3'd1, 32'h0000_5002, 32'h0,         4'h0, 0, 0, 5, 2'b00, 32'h1122_3344, 3'd2, 32'h1122_3344};
        vecs[8]  = '{1'b1, 3'd3, 32'h0000_6000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00, 32'h0,        3'd4, 32'h0};
        vecs[9]  = '{1'b0, 3'd7, 32'h0000_6100, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h0,        3'd4, 32'h0};
        // Response lands in the very cycle the counter reaches TIMEOUT_CYCLES-1: response wins.
        vecs[10] = '{1'b0, 3'd2, 32'h0000_6200, 32'h0,         4'h0, 0, 0, 14, 2'b00, 32'h1357_9BDF, 3'd2, 32'h1357_9BDF};

        // Clock/reset
        ares = 1'b1;
        cmd_empty_i = 1'b1; cmd_write_i = 1'b0; cmd_size_i = '0; cmd_addr_i = '0;
        cmd_wdata_i = '0; cmd_wstrb_i = '0; rsp_full_i = 1'b0; clr_timeout_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = '0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b1;
        tick();
        tick();
        cur = "reset";
        check("reset_outputs", 64'(any_output()), 64'(0));
        ares = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            cur = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        // Timeout with arready withheld, then drain of the late AR/R.
        cur = "timeout";
        hv = '{1'b0, 3'd2, 32'h0000_7000, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h0, 3'd6, 32'h0};
        exp_q.push_back({3'd6, 32'h0});
        push_cmd(hv);
        for (int k = 0; k < TO; k++) begin
            check("arvalid_stall", 64'(arvalid_o), 64'(1));
            check("no_early_rsp", 64'(rsp_wr_o), 64'(0));
            tick();
        end
        check("to_rsp", 64'(rsp_wr_o), 64'(1));
        check("to_flag", 64'(timeout_o), 64'(1));
        check("to_arvalid_kept", 64'(arvalid_o), 64'(1));
        tick();
        hv = '{1'b0, 3'd2, 32'h0000_7100, 32'h0, 4'h0, 1, 0, 2, 2'b00, 32'h7777_0000, 3'd2, 32'h7777_0000};
        set_cmd(hv);
        #1;
        check("drain_no_pop", {cmd_rd_o, busy_o}, {1'b0, 1'b1});
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("drain_ar_done", {arvalid_o, rready_o, cmd_rd_o}, {1'b0, 1'b1, 1'b0});
        rvalid_i = 1'b1;
        rdata_i  = 32'hFFFF_FFFF;
        tick();
        rvalid_i = 1'b0;
        rdata_i  = '0;
        check("drain_exit_pop", {cmd_rd_o, rsp_wr_o}, {1'b1, 1'b0});
        cur = "after_drain";
        exp_q.push_back({hv.exp_status, hv.exp_rdata});
        push_cmd(hv);
        read_slave(hv);
        check("to_sticky", 64'(timeout_o), 64'(1));
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0;
        check("to_cleared", 64'(timeout_o), 64'(0));

        // Response FIFO backpressure with a second command queued behind it.
        cur = "backpressure";
        rsp_full_i = 1'b1;
        hv = '{1'b0, 3'd2, 32'h0000_8000, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h600D_CAFE, 3'd2, 32'h600D_CAFE};
        exp_q.push_back({3'd2, 32'h600D_CAFE});
        push_cmd(hv);
        hv = '{1'b0, 3'd2, 32'h0000_9000, 32'h0, 4'h0, 0, 0, 1, 2'b01, 32'h0000_9999, 3'd3, 32'h0000_9999};
        set_cmd(hv);
        check("bp_araddr_held", 64'(araddr_o), 64'(32'h0000_8000));
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 32'h600D_CAFE;
        rresp_i  = 2'b00;
        tick();
        rvalid_i = 1'b0;
        rdata_i  = '0;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {rsp_wr_o, cmd_rd_o, busy_o, timeout_o}, {1'b0, 1'b0, 1'b1, 1'b0});
            tick();
        end
        rsp_full_i = 1'b0;
        #1;
        check("bp_push", 64'(rsp_wr_o), 64'(1));
        tick();
        check("bp_next_pop", {cmd_rd_o, rsp_wr_o}, {1'b1, 1'b0});
        cur = "bp_second";
        run_vec(hv);

        // Asynchronous reset while waiting for a write response.
        cur = "mid_reset";
        hv = '{1'b1, 3'd2, 32'h0000_A000, 32'h0102_0304, 4'hF, 0, 0, 0, 2'b00, 32'h0, 3'd2, 32'h0};
        push_cmd(hv);
        awready_i = 1'b1;
        wready_i  = 1'b1;
        tick();
        awready_i = 1'b0;
        wready_i  = 1'b0;
        check("in_wresp", {bready_o, busy_o}, {1'b1, 1'b1});
        ares = 1'b1;
        #1;
        check("async_outputs", 64'(any_output()), 64'(0));
        tick();
        ares = 1'b0;
        tick();
        cur = "post_reset";
        hv = '{1'b0, 3'd2, 32'h0000_B000, 32'h0, 4'h0, 1, 0, 1, 2'b00, 32'hB0B0_B0B0, 3'd2, 32'hB0B0_B0B0};
        run_vec(hv);

        tick();
        tick();
        cur = "end";
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
